// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the zero register
// and the store-buffer entry layout.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Writeback source select: loaded data or ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] mem_data,
    input logic [DATA_W-1:0] alu_data
  );
    logic [DATA_W-1:0] result;
    if (mem_to_reg) begin
      result = mem_data;
    end else begin
      result = alu_data;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_commit_unit_checker.sv
// Run-time invariants for the commit unit's store port and stall output.
module wb_commit_unit_checker
  import mips_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input logic              clk,
  input logic              reset,
  input logic              MemWrite_in,
  input logic              sb_stall,
  input logic              st_valid,
  input logic              st_ready,
  input logic [DATA_W-1:0] st_addr,
  input logic [DATA_W-1:0] st_data,
  input logic [CNT_W-1:0]  sb_count
);

  logic              hold_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;

  // Remember the head while the memory side is back-pressuring
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= 1'b0;
      addr_r <= {DATA_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else begin
      hold_r <= st_valid & ~st_ready;
      addr_r <= st_addr;
      data_r <= st_data;
    end
  end

  // Occupancy, stall cause and head stability under back-pressure
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (st_valid == (sb_count != {CNT_W{1'b0}}));
      assert (sb_count <= CNT_W'(SB_DEPTH));
      assert (!sb_stall || MemWrite_in);
      if (hold_r) begin
        assert ((st_addr == addr_r) && (st_data == data_r));
      end
    end
  end

endmodule

// File: rtl/wb_store_fifo.sv
// In-order store buffer with first-word fall-through head; a push into a
// full buffer is accepted only when the head pops in the same cycle.
module wb_store_fifo
  import mips_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  output logic [DATA_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(SB_DEPTH):0] count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(SB_DEPTH);

  sb_entry_t        entries_r [SB_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign full      = (count_r == DEPTH_CNT);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign count     = count_r;
  assign head_addr = entries_r[head_r].addr;
  assign head_data = entries_r[head_r].data;

  // Entry storage: tail slot written on push, all slots cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries_r[i].addr <= {DATA_W{1'b0}};
        entries_r[i].data <= {DATA_W{1'b0}};
      end
    end else if (do_push_s) begin
      entries_r[tail_r].addr <= push_addr;
      entries_r[tail_r].data <= push_data;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        tail_r <= tail_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// MEM/WB consumer: register-file writeback, in-order store buffer and retire counter.
// Define WB_BYPASS_EN to forward the same-cycle writeback value onto the read ports.
module wb_commit_unit
  import mips_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemToReg_in,
  input  logic                      RegWrite_in,
  input  logic                      MemWrite_in,
  input  logic [DATA_W-1:0]         mem_read_data_in,
  input  logic [DATA_W-1:0]         alu_result_in,
  input  logic [REG_ADDR_W-1:0]     write_reg_in,
  input  logic [DATA_W-1:0]         store_data_in,
  input  logic [REG_ADDR_W-1:0]     rs_addr,
  input  logic [REG_ADDR_W-1:0]     rt_addr,
  output logic [DATA_W-1:0]         rs_data,
  output logic [DATA_W-1:0]         rt_data,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [DATA_W-1:0]         st_addr,
  output logic [DATA_W-1:0]         st_data,
  output logic                      sb_stall,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic [31:0]               retire_count
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(SB_DEPTH) + 1;

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [31:0]       retire_r;
  logic [DATA_W-1:0] wb_data_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              commit_s;
  logic              reg_we_s;
  logic              push_s;

  assign wb_data_s = wb_select(MemToReg_in, mem_read_data_in, alu_result_in);
  assign st_valid  = ~empty_s;
  assign pop_s     = st_valid & st_ready;
  // A full buffer only blocks a store when the head is not leaving this cycle
  assign sb_stall  = MemWrite_in & full_s & ~pop_s;
  assign commit_s  = ~sb_stall;
  assign reg_we_s  = commit_s & RegWrite_in & (write_reg_in != ZERO_REG);
  assign push_s    = commit_s & MemWrite_in;

  assign retire_count = retire_r;

  wb_store_fifo #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_addr (alu_result_in),
    .push_data (store_data_in),
    .head_addr (st_addr),
    .head_data (st_data),
    .full      (full_s),
    .empty     (empty_s),
    .count     (sb_count)
  );

  // Register file: cleared on reset, written by committing non-zero destinations
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_r[write_reg_in] <= wb_data_s;
    end
  end

  // Retired-instruction counter, wraps at 2**32
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_r <= 32'd0;
    end else if (commit_s & (RegWrite_in | MemWrite_in)) begin
      retire_r <= retire_r + 32'd1;
    end
  end

  // rs read port
  always_comb begin
    rs_data = {DATA_W{1'b0}};
    if (rs_addr == ZERO_REG) begin
      rs_data = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
    end else if (reg_we_s && (rs_addr == write_reg_in)) begin
      rs_data = wb_data_s;
`endif
    end else begin
      rs_data = regs_r[rs_addr];
    end
  end

  // rt read port
  always_comb begin
    rt_data = {DATA_W{1'b0}};
    if (rt_addr == ZERO_REG) begin
      rt_data = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
    end else if (reg_we_s && (rt_addr == write_reg_in)) begin
      rt_data = wb_data_s;
`endif
    end else begin
      rt_data = regs_r[rt_addr];
    end
  end

  wb_commit_unit_checker #(
    .SB_DEPTH (SB_DEPTH),
    .CNT_W    (CNT_W)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .MemWrite_in (MemWrite_in),
    .sb_stall    (sb_stall),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .sb_count    (sb_count)
  );

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: vector table for writeback/read ports,
// store scoreboard checked at the memory port, hand sequences for full/wrap/reset.
module tb_wb_commit_unit;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemToReg_in, RegWrite_in, MemWrite_in;
  logic [31:0] mem_read_data_in, alu_result_in, store_data_in;
  logic [4:0]  write_reg_in, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, st_addr, st_data, retire_count;
  logic        st_valid, st_ready, sb_stall;
  logic [2:0]  sb_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_regs [32];
  logic [31:0] exp_retire;
  logic [31:0] ret_before;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [4:0]  wr;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;
  localparam int NV = 10;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  wb_commit_unit #(.SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in),
    .mem_read_data_in(mem_read_data_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .store_data_in(store_data_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .sb_stall(sb_stall), .sb_count(sb_count), .retire_count(retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Store scoreboard: the head must match the oldest expected store; pop on handshake
  always @(negedge clk) begin
    if (!reset && st_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_head: st_valid=1 with addr 0x%08h, expected no pending store", st_addr);
      end else begin
        chk("st_addr", st_addr, exp_q[0][63:32]);
        chk("st_data", st_data, exp_q[0][31:0]);
        if (st_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic m2r, input logic mw, input logic [4:0] wr,
                        input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] sd);
    RegWrite_in = we; MemToReg_in = m2r; MemWrite_in = mw; write_reg_in = wr;
    mem_read_data_in = mem; alu_result_in = alu; store_data_in = sd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Settle, check the stall prediction, then advance the reference model
  task automatic drive_cycle();
    logic exp_stall;
    #1;
    exp_stall = MemWrite_in && (exp_q.size() == 4) && !st_ready;
    chk("sb_stall", 32'(sb_stall), 32'(exp_stall));
    if (!exp_stall) begin
      if (RegWrite_in && write_reg_in != 5'd0)
        exp_regs[write_reg_in] = MemToReg_in ? mem_read_data_in : alu_result_in;
      if (MemWrite_in) exp_q.push_back({alu_result_in, store_data_in});
      if (RegWrite_in || MemWrite_in) exp_retire = exp_retire + 32'd1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_retire = 32'd0;
  endtask

  task automatic drain(input string name);
    idle();
    st_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      drive_cycle();
      tick();
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain timeout: %0d entries left, expected 0", name, exp_q.size());
    end
    chk({name, " count"}, 32'(sb_count), 32'd0);
    chk({name, " st_valid"}, 32'(st_valid), 32'd0);
    st_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd8,  32'hDEADBEEF, 32'd0,        5'd5,  5'd8,  32'd0,        BYP ? 32'hDEADBEEF : 32'd0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'd0,        32'd0,        5'd0,  5'd8,  32'd0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 5'd8,  32'h0BADF00D, 32'h55,       5'd8,  5'd8,  BYP ? 32'h55 : 32'hDEADBEEF, BYP ? 32'h55 : 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 5'd0,  32'd0,        32'd0,        5'd8,  5'd8,  32'h55,       32'h55};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  32'd0,        32'h1234,     5'd0,  5'd0,  32'd0,        32'd0};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'd0,        32'd0,        5'd0,  5'd8,  32'd0,        32'h55};
    vecs[6] = '{1'b1, 1'b0, 5'd31, 32'hFFFFFFFF, 32'hA5A5A5A5, 5'd31, 5'd8,  BYP ? 32'hA5A5A5A5 : 32'd0, 32'h55};
    vecs[7] = '{1'b1, 1'b1, 5'd1,  32'h12345678, 32'd0,        5'd31, 5'd1,  32'hA5A5A5A5, BYP ? 32'h12345678 : 32'd0};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  32'd0,        32'd0,        5'd1,  5'd31, 32'h12345678, 32'hA5A5A5A5};
    vecs[9] = '{1'b0, 1'b0, 5'd1,  32'd0,        32'h0000FFFF, 5'd1,  5'd1,  32'h12345678, 32'h12345678};

    reset = 1'b1; st_ready = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    idle();
    clear_model();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rs_addr = 5'd5;
    drive_cycle();
    chk("reset rs_data", rs_data, 32'd0);
    chk("reset st_valid", 32'(st_valid), 32'd0);
    chk("reset sb_count", 32'(sb_count), 32'd0);
    chk("reset retire", retire_count, 32'd0);
    tick();

    // Writeback / read-port vectors
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].we, vecs[i].m2r, 1'b0, vecs[i].wr, vecs[i].mem, vecs[i].alu, 32'd0);
      rs_addr = vecs[i].rs;
      rt_addr = vecs[i].rt;
      drive_cycle();
      chk($sformatf("vec%0d rs_data", i), rs_data, vecs[i].exp_rs);
      chk($sformatf("vec%0d rt_data", i), rt_data, vecs[i].exp_rt);
      tick();
    end
    chk("retire after vectors", retire_count, 32'd5);

    // Full register sweep against the model
    idle();
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      drive_cycle();
      chk($sformatf("sweep rs r%0d", i), rs_data, exp_regs[i]);
      chk($sformatf("sweep rt r%0d", 31 - i), rt_data, exp_regs[31 - i]);
      tick();
    end
    rs_addr = 5'd0;
    rt_addr = 5'd0;

    // Fill, stall on full, release on first pop, in-order drain
    st_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h100 + 32'(4 * i), 32'(i + 1));
      drive_cycle();
      tick();
    end
    chk("fill count", 32'(sb_count), 32'd4);
    chk("fill st_valid", 32'(st_valid), 32'd1);
    ret_before = exp_retire;
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h110, 32'd5);
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      chk("stall on full", 32'(sb_stall), 32'd1);
      tick();
    end
    chk("held count", 32'(sb_count), 32'd4);
    chk("held retire", retire_count, ret_before);
    st_ready = 1'b1;
    drive_cycle();
    chk("release stall", 32'(sb_stall), 32'd0);
    tick();
    chk("release count", 32'(sb_count), 32'd4);
    drain("drain1");
    chk("retire after stores", retire_count, exp_retire);

    // Streaming push+pop on a full buffer across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      drive_cycle();
      tick();
    end
    st_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i));
      drive_cycle();
      chk("stream stall", 32'(sb_stall), 32'd0);
      tick();
    end
    chk("stream count", 32'(sb_count), 32'd4);
    drain("drain2");
    chk("retire after stream", retire_count, exp_retire);

    // Reset with pending stores and a live register
    set_in(1'b1, 1'b0, 1'b0, 5'd8, 32'd0, 32'h77, 32'd0);
    drive_cycle();
    tick();
    st_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i));
      drive_cycle();
      tick();
    end
    idle();
    rs_addr = 5'd8;
    drive_cycle();
    chk("pre-reset r8", rs_data, 32'h77);
    chk("pre-reset count", 32'(sb_count), 32'd3);
    tick();
    reset = 1'b1;
    st_ready = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 5'd8, 32'd0, 32'h500, 32'h99);
    clear_model();
    tick();
    reset = 1'b0;
    idle();
    drive_cycle();
    chk("post-reset st_valid", 32'(st_valid), 32'd0);
    chk("post-reset count", 32'(sb_count), 32'd0);
    chk("post-reset r8", rs_data, 32'd0);
    chk("post-reset retire", retire_count, 32'd0);
    tick();
    chk("post-reset count+1", 32'(sb_count), 32'd0);
    st_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
